mdr_mem_if: RTL and testbench

//  Parametrised memory data register with a memory-side req/ack handshake, sub-word access and timeout.

---
 rtl/mdr_pkg.sv | 32 +++
 rtl/mdr_lane_align.sv | 61 ++++++
 rtl/mdr_mem_if.sv | 129 ++++++++++++
 tb/tb_mdr_mem_if.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared types and helpers for the memory data register: FSM states,
// access-size codes and the byte-lane mask used for loads and stores.
package mdr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam int MAX_LANES = 64;

    // Lanes [off, off + 2**size) set, clipped to the real lane count.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size,
                                                       input int         off,
                                                       input int         lanes);
        logic [MAX_LANES-1:0] m;
        int                   nb;
        m  = '0;
        nb = 1 << size;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i >= off && i < off + nb && i < lanes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Combinational lane steering: sub-word load extract/extend, store lane
// replication, byte-enable mask and access legality.
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter  int BITS  = 32,
    localparam int LANES = BITS / 8,
    localparam int OFFW  = $clog2(LANES)
) (
    input  logic [1:0]       cmd_size,
    input  logic [OFFW-1:0]  cmd_off,
    input  logic [BITS-1:0]  mdr,
    output logic [BITS-1:0]  st_data,
    output logic [LANES-1:0] byte_mask,
    output logic             legal,
    input  logic [1:0]       ld_size,
    input  logic [OFFW-1:0]  ld_off,
    input  logic             ld_signed,
    input  logic [BITS-1:0]  rd_data,
    output logic [BITS-1:0]  ld_data
);

    // Largest size code that fits in one BITS-wide word.
    localparam int MAXS = (OFFW < 3) ? OFFW : 3;

    logic [MAX_LANES-1:0] full_mask;
    logic [BITS-1:0]      shifted;
    int                   nbytes;

    always_comb begin
        nbytes    = 1 << cmd_size;
        legal     = (nbytes <= LANES) && ((int'(cmd_off) % nbytes) == 0) &&
                    (cmd_size != SZ_DWORD || LANES >= 8);
        full_mask = lane_mask(cmd_size, int'(cmd_off), LANES);
        byte_mask = full_mask[LANES-1:0];
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        st_data = mdr;
        for (int s = 0; s <= MAXS; s++) begin
            if (cmd_size == 2'(s)) begin
                for (int b = 0; b < BITS; b++) st_data[b] = mdr[b % (8 << s)];
            end
        end
    end

    always_comb begin
        shifted = rd_data >> {ld_off, 3'b000};
        ld_data = shifted;
        for (int s = 0; s <= MAXS; s++) begin
            if (ld_size == 2'(s)) begin
                for (int b = 0; b < BITS; b++) begin
                    ld_data[b] = (b < (8 << s)) ? shifted[b]
                                                : (ld_signed & shifted[(8 << s) - 1]);
                end
            end
        end
    end

endmodule

// File: rtl/mdr_mem_if.sv
// Memory data register with req/ack memory handshake, sub-word loads and
// stores, wait-state tolerance and a sticky error for misalign/timeout.
module mdr_mem_if
    import mdr_pkg::*;
#(
    parameter  int BITS    = 32,
    parameter  int TIMEOUT = 15,
    localparam int LANES   = BITS / 8,
    localparam int OFFW    = $clog2(LANES),
    localparam int CNTW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [BITS-1:0]  busMuxOut,
    input  logic [BITS-1:0]  MDataIn,
    input  logic             enable,
    input  logic             read,
    input  logic             write,
    input  logic [1:0]       size,
    input  logic             signed_ld,
    input  logic [OFFW-1:0]  byte_off,
    input  logic             mem_ack,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [BITS-1:0]  MDataOut,
    output logic [LANES-1:0] byte_en,
    output logic [BITS-1:0]  MDRout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [1:0]      op_size;
    logic [OFFW-1:0] op_off;
    logic            op_signed;

    logic [BITS-1:0]  st_data;
    logic [LANES-1:0] mask;
    logic             legal;
    logic [BITS-1:0]  ld_data;

    mdr_lane_align #(.BITS(BITS)) u_align (
        .cmd_size  (size),
        .cmd_off   (byte_off),
        .mdr       (MDRout),
        .st_data   (st_data),
        .byte_mask (mask),
        .legal     (legal),
        .ld_size   (op_size),
        .ld_off    (op_off),
        .ld_signed (op_signed),
        .rd_data   (MDataIn),
        .ld_data   (ld_data)
    );

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state     <= IDLE;
            cnt       <= '0;
            op_size   <= SZ_BYTE;
            op_off    <= '0;
            op_signed <= 1'b0;
            MDRout    <= '0;
            MDataOut  <= '0;
            byte_en   <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (read || write) begin
                        if (!legal) begin
                            err <= 1'b1;
                        end else begin
                            err       <= 1'b0;
                            cnt       <= '0;
                            op_size   <= size;
                            op_off    <= byte_off;
                            op_signed <= signed_ld;
                            byte_en   <= mask;
                            if (read) begin
                                state  <= RD_WAIT;
                                mem_rd <= 1'b1;
                            end else begin
                                state    <= WR_WAIT;
                                mem_wr   <= 1'b1;
                                MDataOut <= st_data;
                            end
                        end
                    end else if (enable) begin
                        MDRout <= busMuxOut;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    // An ack on the final allowed wait cycle still completes the access.
                    if (mem_ack) begin
                        if (state == RD_WAIT) MDRout <= ld_data;
                        state   <= IDLE;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        byte_en <= '0;
                        done    <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state   <= IDLE;
                            mem_rd  <= 1'b0;
                            mem_wr  <= 1'b0;
                            byte_en <= '0;
                            err     <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_mem_if.sv
// Scoreboard bench for mdr_mem_if: the driver pushes model predictions,
// a passive monitor pops and compares as the DUT presents each outcome.
module tb_mdr_mem_if;

    localparam int BITS    = 32;
    localparam int TIMEOUT = 4;

    logic        clk;
    logic        clear;
    logic [31:0] busMuxOut;
    logic [31:0] MDataIn;
    logic        enable;
    logic        read;
    logic        write;
    logic [1:0]  size;
    logic        signed_ld;
    logic [1:0]  byte_off;
    logic        mem_ack;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] MDataOut;
    logic [3:0]  byte_en;
    logic [31:0] MDRout;
    logic        busy;
    logic        done;
    logic        err;

    mdr_mem_if #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .clear     (clear),
        .busMuxOut (busMuxOut),
        .MDataIn   (MDataIn),
        .enable    (enable),
        .read      (read),
        .write     (write),
        .size      (size),
        .signed_ld (signed_ld),
        .byte_off  (byte_off),
        .mem_ack   (mem_ack),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .MDataOut  (MDataOut),
        .byte_en   (byte_en),
        .MDRout    (MDRout),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {K_LOAD, K_ILLEGAL, K_READ, K_WRITE} kind_e;
    typedef struct {
        kind_e       kind;
        bit          ok;
        logic [31:0] mdr;
        logic [31:0] dout;
        logic [3:0]  ben;
        int          cycles;
    } exp_t;

    exp_t        sbq[$];
    int          checks;
    int          errors;
    logic [31:0] model_mdr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predict the outcome of one command from the access rules.
    function automatic exp_t predict(input bit rd, input bit wr, input bit en,
                                     input logic [1:0] sz, input logic [1:0] off,
                                     input bit sg, input logic [31:0] bus,
                                     input int d, input logic [31:0] ack_data);
        exp_t       e;
        int         nb;
        bit         legal;
        bit [63:0]  msk;
        bit [63:0]  v;
        bit [7:0]   m8;
        nb       = 1 << sz;
        legal    = (nb <= 4) && ((int'(off) % nb) == 0);
        e.kind   = K_LOAD;
        e.ok     = 1'b0;
        e.dout   = '0;
        e.ben    = '0;
        e.cycles = 0;
        if (rd || wr) begin
            if (!legal) begin
                e.kind = K_ILLEGAL;
            end else begin
                e.kind   = rd ? K_READ : K_WRITE;
                e.ok     = (d < TIMEOUT);
                e.cycles = e.ok ? d + 1 : TIMEOUT;
                m8       = ((8'd1 << nb) - 8'd1) << off;
                e.ben    = m8[3:0];
                if (rd && e.ok) begin
                    msk = (64'd1 << (8 * nb)) - 64'd1;
                    v   = (64'(ack_data) >> (8 * int'(off))) & msk;
                    if (sg && v[8 * nb - 1]) v = v | ~msk;
                    model_mdr = v[31:0];
                end
                if (wr) begin
                    for (int j = 0; j < 4; j++) e.dout[8*j +: 8] = model_mdr[8*(j % nb) +: 8];
                end
            end
        end else if (en) begin
            model_mdr = bus;
        end
        e.mdr = model_mdr;
        return e;
    endfunction

    task automatic do_op(input bit rd, input bit wr, input bit en,
                         input logic [1:0] sz, input logic [1:0] off, input bit sg,
                         input logic [31:0] bus, input int d, input logic [31:0] ack_data);
        exp_t e;
        int   n;
        e = predict(rd, wr, en, sz, off, sg, bus, d, ack_data);
        sbq.push_back(e);
        @(posedge clk); #1;
        read = rd; write = wr; enable = en;
        size = sz; byte_off = off; signed_ld = sg; busMuxOut = bus;
        mem_ack = 1'($urandom);
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0; enable = 1'b0; mem_ack = 1'b0;
        if (e.kind == K_READ || e.kind == K_WRITE) begin
            n = e.cycles;
            for (int k = 0; k < n; k++) begin
                mem_ack   = e.ok && (k == d);
                MDataIn   = (e.ok && k == d) ? ack_data : $urandom;
                size      = 2'($urandom);
                byte_off  = 2'($urandom);
                signed_ld = 1'($urandom);
                busMuxOut = $urandom;
                read      = ($urandom_range(0, 3) == 0);
                write     = ($urandom_range(0, 3) == 0);
                enable    = ($urandom_range(0, 3) == 0);
                @(posedge clk); #1;
            end
            read = 1'b0; write = 1'b0; enable = 1'b0; mem_ack = 1'b0;
        end
    endtask

    // Monitor: inputs observed at a negedge are what the next rising edge acts on.
    bit   pending;
    bit   pend_rst;
    bit   inflight;
    int   busy_cnt;
    exp_t cur;

    initial begin
        pending  = 1'b0;
        pend_rst = 1'b0;
        inflight = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (pend_rst) begin
                check("rst_mdr", MDRout, 0);
                check("rst_mem_rd", mem_rd, 0);
                check("rst_mem_wr", mem_wr, 0);
                check("rst_dout", MDataOut, 0);
                check("rst_ben", byte_en, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_err", err, 0);
                if (inflight && sbq.size() > 0) void'(sbq.pop_front());
                inflight = 1'b0;
            end else if (pending) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    cur = sbq[0];
                    case (cur.kind)
                        K_LOAD: begin
                            check("load_mdr", MDRout, cur.mdr);
                            check("load_busy", busy, 0);
                            void'(sbq.pop_front());
                        end
                        K_ILLEGAL: begin
                            check("ill_err", err, 1);
                            check("ill_busy", busy, 0);
                            check("ill_rd", mem_rd, 0);
                            check("ill_wr", mem_wr, 0);
                            check("ill_mdr", MDRout, cur.mdr);
                            void'(sbq.pop_front());
                        end
                        default: begin
                            check("req_busy", busy, 1);
                            check("req_rd", mem_rd, cur.kind == K_READ);
                            check("req_wr", mem_wr, cur.kind == K_WRITE);
                            check("req_ben", byte_en, cur.ben);
                            check("req_err", err, 0);
                            if (cur.kind == K_WRITE) check("req_dout", MDataOut, cur.dout);
                            inflight = 1'b1;
                            busy_cnt = 1;
                        end
                    endcase
                end
            end else if (inflight) begin
                if (busy) begin
                    busy_cnt++;
                    check("wait_rd", mem_rd, cur.kind == K_READ);
                    check("wait_wr", mem_wr, cur.kind == K_WRITE);
                    check("wait_done", done, 0);
                end else begin
                    check("end_done", done, cur.ok);
                    check("end_err", err, !cur.ok);
                    check("end_cycles", busy_cnt, cur.cycles);
                    check("end_rd", mem_rd, 0);
                    check("end_wr", mem_wr, 0);
                    check("end_ben", byte_en, 0);
                    check("end_mdr", MDRout, cur.mdr);
                    if (cur.kind == K_WRITE) check("end_dout", MDataOut, cur.dout);
                    void'(sbq.pop_front());
                    inflight = 1'b0;
                end
            end else begin
                check("idle_done", done, 0);
                check("idle_busy", busy, 0);
                check("idle_rd", mem_rd, 0);
                check("idle_wr", mem_wr, 0);
            end
            pend_rst = !clear;
            pending  = clear && !busy && (read || write || enable);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; model_mdr = '0;
        clear = 1'b0; busMuxOut = '0; MDataIn = '0; enable = 1'b0;
        read = 1'b0; write = 1'b0; size = '0; signed_ld = 1'b0;
        byte_off = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;

        do_op(0, 0, 1, 2'd0, 2'd0, 0, 32'hFFFF_FFFF, 0, 32'h0);
        do_op(1, 0, 0, 2'd0, 2'd3, 1, 32'h0, 2, 32'h8012_3456);
        do_op(0, 0, 1, 2'd0, 2'd0, 0, 32'h0000_ABCD, 0, 32'h0);
        do_op(0, 1, 0, 2'd1, 2'd2, 0, 32'h0, 0, 32'h0);
        do_op(1, 0, 0, 2'd2, 2'd1, 0, 32'h0, 0, 32'h0);
        do_op(1, 0, 0, 2'd1, 2'd0, 0, 32'h0, 1, 32'h1234_F00D);
        do_op(1, 0, 0, 2'd2, 2'd0, 0, 32'h0, 99, 32'h0);
        do_op(1, 0, 0, 2'd3, 2'd0, 0, 32'h0, 0, 32'h0);
        do_op(0, 1, 0, 2'd2, 2'd0, 0, 32'h0, 3, 32'h0);

        // Clear asserted mid-write: the request is abandoned without done.
        begin
            exp_t e;
            e = predict(0, 1, 0, 2'd2, 2'd0, 0, 32'h0, 99, 32'h0);
            sbq.push_back(e);
            @(posedge clk); #1;
            write = 1'b1; size = 2'd2; byte_off = 2'd0;
            @(posedge clk); #1;
            write = 1'b0;
            repeat (2) @(posedge clk);
            #1 clear = 1'b0;
            @(posedge clk); #1;
            clear = 1'b1;
            model_mdr = '0;
        end
        do_op(1, 0, 1, 2'd2, 2'd0, 0, 32'hDEAD_BEEF, 0, 32'hCAFE_0001);

        for (int i = 0; i < 150; i++) begin
            int         t;
            int         nb;
            bit         rd;
            bit         wr;
            bit         en;
            logic [1:0] sz;
            logic [1:0] off;
            t  = $urandom_range(0, 9);
            rd = (t < 4);
            wr = (t >= 4 && t < 8) || (rd && $urandom_range(0, 1) == 1);
            en = (t >= 8) || ($urandom_range(0, 3) == 0);
            sz = 2'($urandom_range(0, 3));
            nb = 1 << sz;
            if ($urandom_range(0, 3) != 0) off = 2'(($urandom_range(0, 3) / nb) * nb);
            else                           off = 2'($urandom_range(0, 3));
            do_op(rd, wr, en, sz, off, 1'($urandom), $urandom,
                  $urandom_range(0, 5), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                mem_ack = 1'($urandom);
                MDataIn = $urandom;
            end
            #0 mem_ack = 1'b0;
        end

        repeat (4) @(posedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
